// File: rtl/exmem_arb_pkg.sv
// Shared types and helpers for the user-BRAM arbiter.
package exmem_arb_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned SEL_W  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    typedef enum logic {
        OWN_WB  = 1'b0,
        OWN_ENG = 1'b1
    } owner_e;

    // Latched request payload of the granted port.
    typedef struct packed {
        logic              we;
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] adr;
        logic [DATA_W-1:0] dat;
    } req_t;

    // Delay counter width: must be able to hold DELAYS itself.
    function automatic int unsigned cnt_width(input int unsigned delays);
        return $clog2(delays + 1);
    endfunction

endpackage

// File: rtl/exmem_arb_pick.sv
// Two-way winner select between the Wishbone and engine requesters.
// EXMEM_ARB_WB_PRIO_EN defined: fixed WB priority on ties.
// Undefined: alternate on ties, favouring whoever was not last owner.
module exmem_arb_pick
    import exmem_arb_pkg::*;
(
    input  logic wb_vld,
    input  logic eng_vld,
    input  logic wb_mask,
    input  logic eng_mask,
    input  logic last_owner,
    output logic grant_c,
    output logic owner_c
);

    logic wb_ok;
    logic eng_ok;

    // A requester being acknowledged this cycle is already done.
    assign wb_ok  = wb_vld  & ~wb_mask;
    assign eng_ok = eng_vld & ~eng_mask;

`ifdef EXMEM_ARB_WB_PRIO_EN
    logic unused_last_owner;
    assign unused_last_owner = last_owner;
`endif

    // Winner select.
    always_comb begin
        grant_c = wb_ok | eng_ok;
        owner_c = 1'(OWN_WB);
`ifdef EXMEM_ARB_WB_PRIO_EN
        if (!wb_ok && eng_ok) begin
            owner_c = 1'(OWN_ENG);
        end
`else
        if (wb_ok && eng_ok) begin
            owner_c = (last_owner == 1'(OWN_WB)) ? 1'(OWN_ENG) : 1'(OWN_WB);
        end else if (eng_ok) begin
            owner_c = 1'(OWN_ENG);
        end
`endif
    end

endmodule

// File: rtl/exmem_bram_arbiter.sv
// Shares the single-port user BRAM between the Wishbone slave and the FIR
// engine port, inserting DELAYS wait cycles before each access to emulate
// slow external memory. Tie policy selected by EXMEM_ARB_WB_PRIO_EN
// (see exmem_arb_pick).
module exmem_bram_arbiter
    import exmem_arb_pkg::*;
#(
    parameter int unsigned DELAYS = 10
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic        eng_req_i,
    input  logic        eng_we_i,
    input  logic [3:0]  eng_sel_i,
    input  logic [31:0] eng_adr_i,
    input  logic [31:0] eng_dat_i,
    output logic        eng_ack_o,
    output logic [31:0] eng_dat_o,
    output logic        bram_en_o,
    output logic [3:0]  bram_we_o,
    output logic [31:0] bram_adr_o,
    output logic [31:0] bram_di_o,
    input  logic [31:0] bram_do_i,
    output logic        busy_o
);

    localparam int unsigned      CNT_W    = cnt_width(DELAYS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DELAYS - 1);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    owner_e           owner_q;
    owner_e           last_owner_q;
    req_t             req_q;
    req_t             wb_req;
    req_t             eng_req;
    logic             grant_c;
    logic             pick_owner_c;

    logic             wbs_ack_d;
    logic [31:0]      wbs_dat_d;
    logic             eng_ack_d;
    logic [31:0]      eng_dat_d;
    logic             bram_en_d;
    logic [3:0]       bram_we_d;
    logic [31:0]      bram_adr_d;
    logic [31:0]      bram_di_d;
    logic             busy_d;
    logic [31:0]      rd_data;

    assign wb_req  = {wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i};
    assign eng_req = {eng_we_i, eng_sel_i, eng_adr_i, eng_dat_i};

    exmem_arb_pick u_pick (
        .wb_vld     (wbs_cyc_i & wbs_stb_i),
        .eng_vld    (eng_req_i),
        .wb_mask    (wbs_ack_o),
        .eng_mask   (eng_ack_o),
        .last_owner (last_owner_q),
        .grant_c    (grant_c),
        .owner_c    (pick_owner_c)
    );

    // State register.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_c) state_d = WAIT;
            WAIT:    if (cnt_q == CNT_LAST) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs.
    always_comb begin
        bram_en_d  = 1'b0;
        bram_we_d  = 4'h0;
        bram_adr_d = bram_adr_o;
        bram_di_d  = bram_di_o;
        wbs_ack_d  = 1'b0;
        wbs_dat_d  = 32'h0;
        eng_ack_d  = 1'b0;
        eng_dat_d  = 32'h0;
        busy_d     = (state_d != IDLE);
        rd_data    = req_q.we ? 32'h0 : bram_do_i;
        if (state_d == ACCESS) begin
            bram_en_d  = 1'b1;
            bram_we_d  = req_q.we ? req_q.sel : 4'h0;
            bram_adr_d = req_q.adr;
            bram_di_d  = req_q.dat;
        end
        if (state_q == RESP) begin
            if (owner_q == OWN_WB) begin
                wbs_ack_d = 1'b1;
                wbs_dat_d = rd_data;
            end else begin
                eng_ack_d = 1'b1;
                eng_dat_d = rd_data;
            end
        end
    end

    // Request latch, delay counter and round-robin history.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            cnt_q        <= '0;
            owner_q      <= OWN_WB;
            last_owner_q <= OWN_ENG;
            req_q        <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_c) begin
                        cnt_q   <= '0;
                        owner_q <= owner_e'(pick_owner_c);
                        req_q   <= (pick_owner_c == 1'(OWN_ENG)) ? eng_req : wb_req;
                    end
                end
                WAIT:    cnt_q <= cnt_q + CNT_W'(1);
                RESP:    last_owner_q <= owner_q;
                default: ;
            endcase
        end
    end

    // Registered outputs.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbs_ack_o  <= 1'b0;
            wbs_dat_o  <= 32'h0;
            eng_ack_o  <= 1'b0;
            eng_dat_o  <= 32'h0;
            bram_en_o  <= 1'b0;
            bram_we_o  <= 4'h0;
            bram_adr_o <= 32'h0;
            bram_di_o  <= 32'h0;
            busy_o     <= 1'b0;
        end else begin
            wbs_ack_o  <= wbs_ack_d;
            wbs_dat_o  <= wbs_dat_d;
            eng_ack_o  <= eng_ack_d;
            eng_dat_o  <= eng_dat_d;
            bram_en_o  <= bram_en_d;
            bram_we_o  <= bram_we_d;
            bram_adr_o <= bram_adr_d;
            bram_di_o  <= bram_di_d;
            busy_o     <= busy_d;
        end
    end

endmodule

// File: doc/exmem_bram_arbiter.md
# exmem_bram_arbiter

Shares the single-port user BRAM between the Wishbone slave (management SoC) and an internal engine port (FIR tap/data fetch). It serialises requests, inserts a configurable access delay emulating slow external memory, drives the BRAM, and returns a one-cycle acknowledge with read data to the winning requester. It sits in the user project between the Wishbone bus, the FIR engine and the `bram` instance.

## Interface
- `DELAYS`, 10, wait cycles inserted before each BRAM access; legal range 1..255
- `wb_clk_i`  in  1  sole clock
- `wb_rst_i`  in  1  reset, synchronous, active-high
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i`  in  1 each  Wishbone cycle/strobe/write
- `wbs_sel_i`  in  4  byte select
- `wbs_adr_i`, `wbs_dat_i`  in  32 each  address, write data
- `wbs_ack_o`  out  1  one-cycle acknowledge
- `wbs_dat_o`  out  32  read data, valid with `wbs_ack_o`
- `eng_req_i`, `eng_we_i`  in  1 each  engine request (level, held until ack), write
- `eng_sel_i`  in  4  byte select
- `eng_adr_i`, `eng_dat_i`  in  32 each  address, write data
- `eng_ack_o`  out  1  one-cycle acknowledge
- `eng_dat_o`  out  32  read data, valid with `eng_ack_o`
- `bram_en_o`  out  1  BRAM enable
- `bram_we_o`  out  4  BRAM byte write enables
- `bram_adr_o`, `bram_di_o`  out  32 each  BRAM address, write data
- `bram_do_i`  in  32  BRAM read data, one cycle after enable
- `busy_o`  out  1  high whenever state is not IDLE

## Operation
- WB request valid = `wbs_cyc_i & wbs_stb_i`; engine valid = `eng_req_i`. A requester whose ack is high this cycle is masked (no re-grant of a completed request).
- States: IDLE, WAIT, ACCESS, RESP.
- IDLE: if any valid, pick winner, latch owner, adr, dat, sel, we; counter := 0; go WAIT.
- WAIT: counter increments; at counter == DELAYS-1 go ACCESS.
- ACCESS (exactly one cycle): `bram_en_o`=1, `bram_we_o` = latched sel if we else 0, `bram_adr_o`/`bram_di_o` = latched values (address passed unchanged); go RESP.
- RESP (one cycle): capture `bram_do_i` for reads (0 for writes) into owner's dat register, set owner's ack register; update last-owner; go IDLE.
- Tie policy (both valid in IDLE): grant requester that was not last owner. Last-owner resets to engine, so WB wins first tie.
- Requester drops request mid-transaction: access still completes (write committed), ack still pulsed; no abort.
- Outside ACCESS, `bram_en_o`=0, `bram_we_o`=0.

## Timing
- Reset values: all acks 0, all dat_o 0, `bram_en_o` 0, `bram_we_o` 0, `bram_adr_o`/`bram_di_o` 0, `busy_o` 0, state IDLE, counter 0, last-owner engine.
- Reset mid-operation: next cycle IDLE, no ack issued, no BRAM access; pending write not committed unless ACCESS already occurred.
- Request first valid in IDLE at cycle T: ACCESS at T+DELAYS+1, ack (registered) at T+DELAYS+3; ack high exactly one cycle; dat_o returns to 0 the cycle after ack.
- Back-to-back: new grant possible in the ack cycle (state is IDLE) for the other requester; same requester earliest one cycle after its ack.
- Throughput: one access per DELAYS+3 cycles.

## Configuration
- `EXMEM_ARB_WB_PRIO_EN` defined: fixed priority, WB always wins ties, last-owner unused (engine can starve).
- Undefined: alternating round-robin as in Operation.

## Structure
- Package `exmem_arb_pkg`: state enum (IDLE, WAIT, ACCESS, RESP), owner encoding (OWN_WB=0, OWN_ENG=1), counter width localparam `$clog2(DELAYS+1)`.
- One sub-module: `exmem_arb_pick`, combinational two-way winner select from valids, masks and last-owner, containing the `EXMEM_ARB_WB_PRIO_EN` switch.

## Test plan
- WB write 0xDEADBEEF to 0x3800_0000, sel 0xF, DELAYS=10 -> `bram_en_o`/`bram_we_o`=0xF at T+11, `wbs_ack_o` at T+13, `eng_ack_o` never.
- WB read after that write -> `wbs_dat_o`=0xDEADBEEF with ack at T+13; sel 0x3 write 0x0000_1234 then read -> 0xDEAD1234.
- Both request simultaneously from reset, repeated 4 times (round-robin) -> grant order WB, ENG, WB, ENG; with `EXMEM_ARB_WB_PRIO_EN` -> WB each time until WB idle.
- Engine read while WB continuously requesting -> engine ack within 2×(DELAYS+3) cycles (round-robin build).
- Assert `wb_rst_i` in WAIT of a write -> no ack, `bram_en_o` never high, subsequent read returns old contents.
- WB drops cyc in WAIT of a write -> write still committed at ACCESS, ack pulses once, next request served normally.
